canvas_write_scheduler: RTL and testbench

Arbitrates and sequences all pixel writes into the canvas framebuffer. It shares the single framebuffer write port between two requesters. The first is the paint requester: the cursor position plus the 3-bit color code from the color selector, where 3'b111 means white/erase. The second is a clear-canvas sweep that fills the whole framebuffer with white. It sits between the input/color logic and the framebuffer BRAM, which the VGA scan-out reads through its other port.

---
 rtl/canvas_write_scheduler_if.sv | 34 +++
 rtl/canvas_write_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_canvas_write_scheduler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/canvas_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : canvas_write_scheduler_if
// Purpose  : Paint/clear request handshakes and framebuffer write port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface canvas_write_scheduler_if #(
    parameter int ADDR_W = 15
);
    logic              paint_req;
    logic [7:0]        paint_x;
    logic [6:0]        paint_y;
    logic [2:0]        paint_color;
    logic              paint_ack;
    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [2:0]        fb_data;

    // Requester / framebuffer side
    modport master (
        output paint_req, paint_x, paint_y, paint_color, clear_req,
        input  paint_ack, clear_busy, clear_done, fb_we, fb_addr, fb_data
    );

    // Scheduler side
    modport slave (
        input  paint_req, paint_x, paint_y, paint_color, clear_req,
        output paint_ack, clear_busy, clear_done, fb_we, fb_addr, fb_data
    );
endinterface
`default_nettype wire

// File: rtl/canvas_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : canvas_write_scheduler
// Purpose  : Shares the framebuffer write port between paint and clear sweep.
//            Define BRUSH_3X3_EN for a 9-cycle 3x3 brush instead of one pixel.
// Revision : 1.0 - initial release
// ============================================================================
module canvas_write_scheduler #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int ADDR_W = 15
) (
    input  logic clk,
    input  logic rst_n,
    canvas_write_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PAINT = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(H_RES * V_RES - 1);

    // Brush offsets are indexed 0..8 row-major; index 4 is the centre pixel.
`ifdef BRUSH_3X3_EN
    localparam logic [3:0] c_OFF_FIRST = 4'd0;
    localparam logic [3:0] c_OFF_LAST  = 4'd8;
`else
    localparam logic [3:0] c_OFF_FIRST = 4'd4;
    localparam logic [3:0] c_OFF_LAST  = 4'd4;
`endif

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_off, w_off_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_pend, w_pend_nxt;
    logic [7:0]        r_x, w_x_nxt;
    logic [6:0]        r_y, w_y_nxt;
    logic [2:0]        r_color, w_color_nxt;

    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [2:0]        r_data, w_data_nxt;
    logic              r_ack, w_ack_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    logic [7:0]        w_src_x;
    logic [6:0]        w_src_y;
    logic [2:0]        w_src_color;
    logic [3:0]        w_src_off;
    logic [1:0]        w_dxi, w_dyi;
    logic [9:0]        w_px, w_py;
    logic              w_pix_in;
    logic [ADDR_W-1:0] w_pix_addr;

    // Pixel for the next paint cycle: fresh inputs on accept, latched afterwards.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_src_x     = bus.paint_x;
            w_src_y     = bus.paint_y;
            w_src_color = bus.paint_color;
            w_src_off   = c_OFF_FIRST;
        end else begin
            w_src_x     = r_x;
            w_src_y     = r_y;
            w_src_color = r_color;
            w_src_off   = r_off + 4'd1;
        end
    end

    always_comb begin
        w_dxi = 2'd1;
        w_dyi = 2'd1;
        case (w_src_off)
            4'd0:    begin w_dxi = 2'd0; w_dyi = 2'd0; end
            4'd1:    begin w_dxi = 2'd1; w_dyi = 2'd0; end
            4'd2:    begin w_dxi = 2'd2; w_dyi = 2'd0; end
            4'd3:    begin w_dxi = 2'd0; w_dyi = 2'd1; end
            4'd5:    begin w_dxi = 2'd2; w_dyi = 2'd1; end
            4'd6:    begin w_dxi = 2'd0; w_dyi = 2'd2; end
            4'd7:    begin w_dxi = 2'd1; w_dyi = 2'd2; end
            4'd8:    begin w_dxi = 2'd2; w_dyi = 2'd2; end
            default: begin w_dxi = 2'd1; w_dyi = 2'd1; end
        endcase
        // A negative coordinate wraps to a large unsigned value, so one compare rejects both edges.
        w_px       = {2'b00, w_src_x} + {8'd0, w_dxi} - 10'd1;
        w_py       = {3'b000, w_src_y} + {8'd0, w_dyi} - 10'd1;
        w_pix_in   = (w_px < 10'(H_RES)) && (w_py < 10'(V_RES));
        w_pix_addr = ADDR_W'(w_py) * ADDR_W'(H_RES) + ADDR_W'(w_px);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_off_nxt   = r_off;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_color_nxt = r_color;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_data_nxt  = 3'b000;
        w_ack_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.clear_req || r_pend) begin
                    w_state_nxt = S_CLEAR;
                    w_pend_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_we_nxt    = 1'b1;
                    w_data_nxt  = 3'b111;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = (c_LAST == '0);
                end else if (bus.paint_req) begin
                    w_state_nxt = S_PAINT;
                    w_off_nxt   = c_OFF_FIRST;
                    w_x_nxt     = bus.paint_x;
                    w_y_nxt     = bus.paint_y;
                    w_color_nxt = bus.paint_color;
                    w_we_nxt    = w_pix_in;
                    w_addr_nxt  = w_pix_in ? w_pix_addr : '0;
                    w_data_nxt  = w_pix_in ? w_src_color : 3'b000;
                    w_ack_nxt   = (c_OFF_FIRST == c_OFF_LAST);
                end
            end
            S_PAINT: begin
                if (bus.clear_req) begin
                    w_pend_nxt = 1'b1;
                end
                if (r_off == c_OFF_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_off_nxt  = r_off + 4'd1;
                    w_we_nxt   = w_pix_in;
                    w_addr_nxt = w_pix_in ? w_pix_addr : '0;
                    w_data_nxt = w_pix_in ? w_src_color : 3'b000;
                    w_ack_nxt  = (w_src_off == c_OFF_LAST);
                end
            end
            S_CLEAR: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt  = r_cnt + ADDR_W'(1);
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = r_cnt + ADDR_W'(1);
                    w_data_nxt = 3'b111;
                    w_busy_nxt = 1'b1;
                    w_done_nxt = ((r_cnt + ADDR_W'(1)) == c_LAST);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_off   <= 4'd0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_x     <= 8'd0;
            r_y     <= 7'd0;
            r_color <= 3'b000;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= 3'b000;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_off   <= w_off_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_color <= w_color_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.fb_we      = r_we;
    assign bus.fb_addr    = r_addr;
    assign bus.fb_data    = r_data;
    assign bus.paint_ack  = r_ack;
    assign bus.clear_busy = r_busy;
    assign bus.clear_done = r_done;
endmodule
`default_nettype wire

// File: tb/tb_canvas_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_canvas_write_scheduler
// Purpose  : Directed and randomized checks of canvas_write_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_canvas_write_scheduler;
    localparam int H    = 160;
    localparam int V    = 120;
    localparam int AW   = 15;
    localparam int NPIX = H * V;
`ifdef BRUSH_3X3_EN
    localparam int NP = 9;
    localparam bit BR = 1'b1;
`else
    localparam int NP = 1;
    localparam bit BR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    canvas_write_scheduler_if #(.ADDR_W(AW)) bus ();

    canvas_write_scheduler #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire [21:0] w_obs = {bus.fb_we, bus.fb_addr, bus.fb_data,
                         bus.paint_ack, bus.clear_busy, bus.clear_done};

    function automatic logic [21:0] mk(input logic we, input logic [AW-1:0] a,
                                       input logic [2:0] d, input logic ack,
                                       input logic busy, input logic done);
        return {we, a, d, ack, busy, done};
    endfunction

    // Expected output of the k-th cycle of a paint at (x,y) with color c.
    function automatic logic [21:0] model_pix(input int x, input int y,
                                              input logic [2:0] c, input int k);
        int dx, dy, px, py;
        bit inr;
        dx  = BR ? (k % 3) - 1 : 0;
        dy  = BR ? (k / 3) - 1 : 0;
        px  = x + dx;
        py  = y + dy;
        inr = (px >= 0) && (px < H) && (py >= 0) && (py < V);
        return mk(inr, inr ? AW'(py * H + px) : '0, inr ? c : 3'b000,
                  (k == NP - 1), 1'b0, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [21:0] exp);
        n_cmp++;
        assert (w_obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, w_obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_paint(input int x, input int y, input logic [2:0] c);
        bus.paint_req   = 1'b1;
        bus.paint_x     = 8'(x);
        bus.paint_y     = 7'(y);
        bus.paint_color = c;
        tick();
    endtask

    task automatic check_paint(input int x, input int y, input logic [2:0] c,
                               input string tag);
        for (int k = 0; k < NP; k++) begin
            chk(tag, model_pix(x, y, c, k));
            if (k < NP - 1) tick();
        end
    endtask

    // Checks n sweep cycles starting at the one currently visible; re-pokes clear_req mid-sweep.
    task automatic check_clear(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(tag, mk(1'b1, AW'(i), 3'b111, 1'b0, 1'b1, (i == NPIX - 1)));
            if (i == 1000) bus.clear_req = 1'b1;
            if (i == 1001) bus.clear_req = 1'b0;
            if (i < n - 1) tick();
        end
    endtask

    initial begin
        int x, y;
        int ex[6];
        int ey[6];
        logic [2:0] c;
        bit hold;
        ex = '{0, 159, 160, 0, 255, 158};
        ey = '{0, 119, 0, 120, 127, 60};
        bus.paint_req   = 1'b0;
        bus.paint_x     = 8'd0;
        bus.paint_y     = 7'd0;
        bus.paint_color = 3'b000;
        bus.clear_req   = 1'b0;

        #2 rst_n = 1'b0;
        tick();
        chk("reset", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));

        start_paint(10, 5, 3'b001);
        check_paint(10, 5, 3'b001, "paint_10_5");
        bus.paint_req = 1'b0;
        tick();
        chk("idle_after_paint", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < 30; i++) begin
            if (i < 6) begin
                x = ex[i];
                y = ey[i];
            end else begin
                x = int'($urandom_range(0, 175));
                y = int'($urandom_range(0, 127));
            end
            c    = 3'($urandom_range(0, 7));
            hold = 1'($urandom_range(0, 1));
            start_paint(x, y, c);
            check_paint(x, y, c, "paint_rand");
            if (!hold) bus.paint_req = 1'b0;
            tick();
            chk("paint_gap", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));
        end
        bus.paint_req = 1'b0;
        tick();
        chk("idle_after_rand", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));

        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        check_clear(NPIX, "clear_sweep");
        tick();
        chk("clear_end", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));

        x = int'($urandom_range(1, H - 2));
        y = int'($urandom_range(1, V - 2));
        c = 3'($urandom_range(0, 6));
        bus.paint_req   = 1'b1;
        bus.paint_x     = 8'(x);
        bus.paint_y     = 7'(y);
        bus.paint_color = c;
        bus.clear_req   = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        check_clear(NPIX, "clear_over_paint");
        tick();
        chk("gap_after_clear", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));
        tick();
        check_paint(x, y, c, "paint_after_clear");
        bus.paint_req = 1'b0;
        tick();
        chk("single_ack", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));

        x = int'($urandom_range(0, H - 1));
        y = int'($urandom_range(0, V - 1));
        c = 3'($urandom_range(0, 7));
        start_paint(x, y, c);
        bus.clear_req = 1'b1;
        check_paint(x, y, c, "paint_with_pend");
        bus.paint_req = 1'b0;
        tick();
        bus.clear_req = 1'b0;
        chk("pend_idle", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));
        tick();
        check_clear(NPIX, "pend_clear");
        tick();
        chk("pend_clear_end", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));

        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        check_clear(501, "clear_pre_rst");
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sweep", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));
        tick();
        chk("rst_held", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        tick();
        chk("idle_post_rst", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        check_clear(600, "clear_restart");
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sweep2", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_post_rst2", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));

        start_paint(20, 20, 3'b011);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_paint", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));
        bus.paint_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_post_paint_rst", mk(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
